// File: rtl/gpu_pkg.sv
// Shared types for the GPU draw sequencer: opcodes, FSM states, instruction field layout
// and a constant-multiplier helper used only to seed the start address of a command.
package gpu_pkg;

    typedef enum logic [3:0] {
        OP_NOP    = 4'd0,
        OP_PIXEL  = 4'd1,
        OP_HLINE  = 4'd2,
        OP_VLINE  = 4'd3,
        OP_SQUARE = 4'd4,
        OP_CLEAR  = 4'd5
    } gpu_op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_DRAW
    } draw_state_t;

    localparam int OP_LSB    = 28;
    localparam int OP_W      = 4;
    localparam int X_LSB     = 20;
    localparam int X_W       = 8;
    localparam int Y_LSB     = 13;
    localparam int Y_W       = 7;
    localparam int LEN_LSB   = 5;
    localparam int LEN_W     = 8;
    localparam int COLOR_LSB = 2;

    // Cursor width: one bit wider than the X field so X+LEN never wraps.
    localparam int CUR_W = 9;

    // Shift-and-add by a constant; reduces to a few adders, not a multiplier.
    function automatic logic [31:0] times_const(input logic [CUR_W-1:0] v, input int unsigned k);
        logic [31:0] acc;
        // NOTE: blocking assignments are correct inside functions and always_comb;
        // non-blocking is reserved for clocked state.
        acc = '0;
        for (int i = 0; i < 16; i++) begin
            if (k[i]) acc = acc + ({23'd0, v} << i);
        end
        return acc;
    endfunction

endpackage

// File: rtl/gpu_pixel_cursor.sv
// Pixel cursor: walks a w x h rectangle row-major from (x0,y0), tracking the framebuffer
// address incrementally and flagging the last pixel and off-screen (clipped) pixels.
module gpu_pixel_cursor
    import gpu_pkg::*;
#(
    parameter int H_RES  = 160,
    parameter int V_RES  = 120,
    parameter int ADDR_W = 15
) (
    input  logic              hf_clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [CUR_W-1:0]  x0_i,
    input  logic [CUR_W-1:0]  y0_i,
    input  logic [CUR_W-1:0]  w_i,
    input  logic [CUR_W-1:0]  h_i,
    input  logic [ADDR_W-1:0] addr0_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o,
    output logic              clip_o
);

    localparam logic [CUR_W-1:0] H_LIM = CUR_W'(H_RES);
    localparam logic [CUR_W-1:0] V_LIM = CUR_W'(V_RES);

    logic [CUR_W-1:0]  x_q, x_d, y_q, y_d, x0_q, x0_d;
    logic [CUR_W-1:0]  w_q, w_d, h_q, h_d, col_q, col_d, row_q, row_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              row_end;

    assign row_end = (col_q == w_q - CUR_W'(1));
    assign last_o  = row_end && (row_q == h_q - CUR_W'(1));
    assign clip_o  = (x_q >= H_LIM) || (y_q >= V_LIM);
    assign addr_o  = addr_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        x_d    = x_q;
        y_d    = y_q;
        x0_d   = x0_q;
        w_d    = w_q;
        h_d    = h_q;
        col_d  = col_q;
        row_d  = row_q;
        addr_d = addr_q;
        if (load_i) begin
            x_d    = x0_i;
            y_d    = y0_i;
            x0_d   = x0_i;
            w_d    = w_i;
            h_d    = h_i;
            col_d  = '0;
            row_d  = '0;
            addr_d = addr0_i;
        end else if (step_i) begin
            if (row_end) begin
                // Row return: back to x0 on the next row. Modular address arithmetic keeps
                // the low bits exact even while the cursor is off-screen.
                x_d    = x0_q;
                y_d    = y_q + CUR_W'(1);
                col_d  = '0;
                row_d  = row_q + CUR_W'(1);
                addr_d = addr_q + ADDR_W'(H_RES) - ADDR_W'(w_q - CUR_W'(1));
            end else begin
                x_d    = x_q + CUR_W'(1);
                col_d  = col_q + CUR_W'(1);
                addr_d = addr_q + ADDR_W'(1);
            end
        end
    end

    // NOTE: clocked state uses non-blocking assignments so all registers update together.
    always_ff @(posedge hf_clk_i or posedge rst_i) begin
        if (rst_i) begin
            x_q    <= '0;
            y_q    <= '0;
            x0_q   <= '0;
            w_q    <= '0;
            h_q    <= '0;
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            x0_q   <= x0_d;
            w_q    <= w_d;
            h_q    <= h_d;
            col_q  <= col_d;
            row_q  <= row_d;
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/gpu_draw_sequencer.sv
// GPU draw sequencer: one-deep pending slot, decode FSM and pixel-by-pixel framebuffer
// writes with ready/valid backpressure.
module gpu_draw_sequencer
    import gpu_pkg::*;
#(
    parameter int H_RES   = 160,
    parameter int V_RES   = 120,
    parameter int COLOR_W = 3,
    parameter int ADDR_W  = $clog2(H_RES * V_RES)
) (
    input  logic               hf_clk_i,
    input  logic               rst_i,
    input  logic [31:0]        instruction_i,
    input  logic               new_instr_i,
    input  logic               fb_ready_i,
    output logic               fb_we_o,
    output logic [ADDR_W-1:0]  fb_addr_o,
    output logic [COLOR_W-1:0] fb_data_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               drop_o,
    output logic               bad_op_o
);

    draw_state_t state_q, state_d;
    logic        slot_valid_q, slot_valid_d;
    logic [31:0] slot_q, slot_d, cmd_q, cmd_d;
    logic        done_q, done_d, drop_q, drop_d, bad_op_q, bad_op_d;
    logic        bypass;

    logic [OP_W-1:0]   op;
    logic [LEN_W-1:0]  len;
    logic [CUR_W-1:0]  x0, y0, w, h;
    logic [ADDR_W-1:0] addr0;
    logic              cur_load, cur_step, cur_last, cur_clip;
    logic              unused_bits;

    assign unused_bits = ^cmd_q[1:0];

    always_comb begin
        op    = cmd_q[OP_LSB +: OP_W];
        len   = cmd_q[LEN_LSB +: LEN_W];
        x0    = CUR_W'(cmd_q[X_LSB +: X_W]);
        y0    = CUR_W'(cmd_q[Y_LSB +: Y_W]);
        w     = CUR_W'(1);
        h     = CUR_W'(1);
        case (op)
            OP_HLINE:  w = CUR_W'(len);
            OP_VLINE:  h = CUR_W'(len);
            OP_SQUARE: begin
                w = CUR_W'(len);
                h = CUR_W'(len);
            end
            OP_CLEAR: begin
                x0 = '0;
                y0 = '0;
                w  = CUR_W'(H_RES);
                h  = CUR_W'(V_RES);
            end
            default: ;
        endcase
        addr0 = ADDR_W'(times_const(y0, H_RES)) + ADDR_W'(x0);
    end

    always_comb begin
        state_d      = state_q;
        slot_valid_d = slot_valid_q;
        slot_d       = slot_q;
        cmd_d        = cmd_q;
        done_d       = 1'b0;
        drop_d       = 1'b0;
        bad_op_d     = 1'b0;
        cur_load     = 1'b0;
        cur_step     = 1'b0;
        bypass       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (slot_valid_q) begin
                    cmd_d        = slot_q;
                    slot_valid_d = 1'b0;
                    state_d      = S_DECODE;
                end else if (new_instr_i) begin
                    // Empty slot: the strobed word goes straight to decode.
                    cmd_d   = instruction_i;
                    bypass  = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_IDLE;
                case (op)
                    OP_NOP: done_d = 1'b1;
                    OP_PIXEL, OP_CLEAR: begin
                        cur_load = 1'b1;
                        state_d  = S_DRAW;
                    end
                    OP_HLINE, OP_VLINE, OP_SQUARE: begin
                        if (len == '0) begin
                            done_d = 1'b1;
                        end else begin
                            cur_load = 1'b1;
                            state_d  = S_DRAW;
                        end
                    end
                    default: bad_op_d = 1'b1;
                endcase
            end
            S_DRAW: begin
                // Clipped pixels are consumed in one cycle without a write.
                cur_step = cur_clip || fb_ready_i;
                if (cur_step && cur_last) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (new_instr_i && !bypass) begin
            if (!slot_valid_q || state_q == S_IDLE) begin
                slot_d       = instruction_i;
                slot_valid_d = 1'b1;
            end else begin
                drop_d = 1'b1;
            end
        end
    end

    always_ff @(posedge hf_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            slot_valid_q <= 1'b0;
            slot_q       <= '0;
            cmd_q        <= '0;
            done_q       <= 1'b0;
            drop_q       <= 1'b0;
            bad_op_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_valid_q <= slot_valid_d;
            slot_q       <= slot_d;
            cmd_q        <= cmd_d;
            done_q       <= done_d;
            drop_q       <= drop_d;
            bad_op_q     <= bad_op_d;
        end
    end

    gpu_pixel_cursor #(
        .H_RES  (H_RES),
        .V_RES  (V_RES),
        .ADDR_W (ADDR_W)
    ) u_cursor (
        .hf_clk_i (hf_clk_i),
        .rst_i    (rst_i),
        .load_i   (cur_load),
        .step_i   (cur_step),
        .x0_i     (x0),
        .y0_i     (y0),
        .w_i      (w),
        .h_i      (h),
        .addr0_i  (addr0),
        .addr_o   (fb_addr_o),
        .last_o   (cur_last),
        .clip_o   (cur_clip)
    );

    assign fb_we_o   = (state_q == S_DRAW) && !cur_clip;
    assign fb_data_o = cmd_q[COLOR_LSB +: COLOR_W];
    assign busy_o    = (state_q != S_IDLE) || slot_valid_q;
    assign done_o    = done_q;
    assign drop_o    = drop_q;
    assign bad_op_o  = bad_op_q;

endmodule

// File: tb/tb_gpu_draw_sequencer.sv
// Self-checking bench for gpu_draw_sequencer: directed scenarios plus randomized commands
// compared against a pixel-list reference model.
module tb_gpu_draw_sequencer;

    localparam int H_RES   = 160;
    localparam int V_RES   = 120;
    localparam int COLOR_W = 3;
    localparam int ADDR_W  = 15;

    logic               hf_clk = 1'b0;
    logic               rst = 1'b1;
    logic [31:0]        instruction = '0;
    logic               new_instr = 1'b0;
    logic               fb_ready = 1'b1;
    logic               fb_we;
    logic [ADDR_W-1:0]  fb_addr;
    logic [COLOR_W-1:0] fb_data;
    logic               busy, done, drop, bad_op;

    always #5 hf_clk = ~hf_clk;

    gpu_draw_sequencer #(
        .H_RES   (H_RES),
        .V_RES   (V_RES),
        .COLOR_W (COLOR_W),
        .ADDR_W  (ADDR_W)
    ) dut (
        .hf_clk_i      (hf_clk),
        .rst_i         (rst),
        .instruction_i (instruction),
        .new_instr_i   (new_instr),
        .fb_ready_i    (fb_ready),
        .fb_we_o       (fb_we),
        .fb_addr_o     (fb_addr),
        .fb_data_o     (fb_data),
        .busy_o        (busy),
        .done_o        (done),
        .drop_o        (drop),
        .bad_op_o      (bad_op)
    );

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int exp_addr[$];
    int exp_data[$];
    int acc_cycle[$];
    int done_cycle[$];
    int wr_idx, bad_seen, drop_seen, first_we;
    int exp_done, exp_bad, exp_drop;
    int ready_pct = 100;
    bit ready_toggle = 1'b0;
    bit tog = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int op, input int x, input int y,
                                       input int len, input int color);
        logic [31:0] w;
        w        = '0;
        w[31:28] = op[3:0];
        w[27:20] = x[7:0];
        w[19:13] = y[6:0];
        w[12:5]  = len[7:0];
        w[4:2]   = color[2:0];
        return w;
    endfunction

    // Reference model: list every visible pixel of the command in drawing order.
    task automatic model(input logic [31:0] ins);
        int op, x0, y0, len, col, w, h;
        op  = int'(ins[31:28]);
        x0  = int'(ins[27:20]);
        y0  = int'(ins[19:13]);
        len = int'(ins[12:5]);
        col = int'(ins[4:2]);
        w   = 0;
        h   = 0;
        case (op)
            0: exp_done++;
            1: begin w = 1;   h = 1;   end
            2: begin w = len; h = 1;   end
            3: begin w = 1;   h = len; end
            4: begin w = len; h = len; end
            5: begin x0 = 0; y0 = 0; w = H_RES; h = V_RES; end
            default: exp_bad++;
        endcase
        if (op >= 1 && op <= 5) begin
            exp_done++;
            for (int r = 0; r < h; r++) begin
                for (int c = 0; c < w; c++) begin
                    if (x0 + c < H_RES && y0 + r < V_RES) begin
                        exp_addr.push_back((y0 + r) * H_RES + x0 + c);
                        exp_data.push_back(col);
                    end
                end
            end
        end
    endtask

    task automatic clear_book();
        exp_addr.delete();
        exp_data.delete();
        acc_cycle.delete();
        done_cycle.delete();
        wr_idx    = 0;
        bad_seen  = 0;
        drop_seen = 0;
        exp_done  = 0;
        exp_bad   = 0;
        exp_drop  = 0;
        first_we  = -1;
    endtask

    // One clock: drive inputs just after the rising edge, observe at the falling edge.
    task automatic tick(input bit strobe, input logic [31:0] word);
        @(posedge hf_clk);
        #1;
        new_instr = strobe;
        if (strobe) instruction = word;
        if (ready_toggle) begin
            tog      = ~tog;
            fb_ready = tog;
        end else begin
            fb_ready = ($urandom_range(0, 99) < ready_pct);
        end
        @(negedge hf_clk);
        cycle++;
        if (fb_we) begin
            if (first_we < 0) first_we = cycle;
            check("write_expected", 32'(wr_idx < exp_addr.size()), 32'd1);
            if (wr_idx < exp_addr.size()) begin
                check("fb_addr", 32'(fb_addr), 32'(exp_addr[wr_idx]));
                check("fb_data", 32'(fb_data), 32'(exp_data[wr_idx]));
            end
            if (fb_ready) begin
                acc_cycle.push_back(cycle);
                wr_idx++;
            end
        end
        if (done)   done_cycle.push_back(cycle);
        if (bad_op) bad_seen++;
        if (drop)   drop_seen++;
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        tick(1'b0, '0);
        while (busy && n < bound) begin
            tick(1'b0, '0);
            n++;
        end
        check("idle_reached", 32'(busy), 32'd0);
    endtask

    task automatic final_checks();
        check("write_count", 32'(wr_idx), 32'(exp_addr.size()));
        check("done_count", 32'(done_cycle.size()), 32'(exp_done));
        check("bad_op_count", 32'(bad_seen), 32'(exp_bad));
        check("drop_count", 32'(drop_seen), 32'(exp_drop));
    endtask

    task automatic run_cmd(input logic [31:0] ins, input int bound, output int s);
        clear_book();
        model(ins);
        tick(1'b1, ins);
        s = cycle;
        wait_idle(bound);
        final_checks();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int op, x, y, len, col, sel;
        logic [31:0] i1, i2, i3;

        clear_book();
        repeat (3) tick(1'b0, '0);
        check("rst_fb_we", 32'(fb_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_drop", 32'(drop), 32'd0);
        check("rst_bad_op", 32'(bad_op), 32'd0);
        check("rst_fb_addr", 32'(fb_addr), 32'd0);
        check("rst_fb_data", 32'(fb_data), 32'd0);
        @(posedge hf_clk);
        #1;
        rst = 1'b0;

        // Single pixel: latency and address 5*160+10.
        ready_pct = 100;
        run_cmd(mk(1, 10, 5, 1, 3), 20, s);
        check("pixel_we_latency", 32'(first_we - s), 32'd2);
        check("pixel_done_latency",
              32'((done_cycle.size() > 0) ? done_cycle[0] - s : -1), 32'd3);

        // HLINE running off the right edge: 2 writes, 4 draw cycles.
        run_cmd(mk(2, 158, 0, 4, 6), 40, s);
        check("hline_clip_done_latency",
              32'((done_cycle.size() > 0) ? done_cycle[0] - s : -1), 32'd6);

        // SQUARE under alternating backpressure.
        ready_toggle = 1'b1;
        run_cmd(mk(4, 2, 2, 2, 5), 60, s);
        ready_toggle = 1'b0;

        // Three strobes during a long HLINE: second held, third dropped.
        clear_book();
        i1 = mk(2, 0, 1, 40, 5);
        i2 = mk(1, 7, 7, 1, 2);
        i3 = mk(1, 9, 9, 1, 6);
        model(i1);
        model(i2);
        exp_drop = 1;
        tick(1'b1, i1);
        repeat (4) tick(1'b0, '0);
        tick(1'b1, i2);
        tick(1'b0, '0);
        tick(1'b1, i3);
        check("busy_with_pending", 32'(busy), 32'd1);
        wait_idle(300);
        final_checks();
        check("held_cmd_first_write",
              32'((acc_cycle.size() > 40 && done_cycle.size() > 0) ?
                  acc_cycle[40] - done_cycle[0] : -1), 32'd2);

        // Reserved opcode, NOP and zero-length line.
        run_cmd(mk(9, 1, 1, 3, 1), 20, s);
        run_cmd(mk(0, 1, 1, 3, 1), 20, s);
        run_cmd(mk(2, 10, 10, 0, 1), 20, s);
        run_cmd(mk(3, 20, 118, 5, 7), 40, s);

        // Randomized commands against the reference model.
        for (int k = 0; k < 30; k++) begin
            sel = $urandom_range(0, 9);
            x   = $urandom_range(0, 255);
            y   = $urandom_range(0, 127);
            len = $urandom_range(0, 12);
            col = $urandom_range(0, 7);
            case (sel)
                0:       op = 0;
                1, 2:    begin op = 1; len = 1; end
                3, 4:    op = 2;
                5, 6:    op = 3;
                7, 8:    op = 4;
                default: op = $urandom_range(6, 15);
            endcase
            ready_pct = $urandom_range(40, 100);
            run_cmd(mk(op, x, y, len, col), 2000, s);
        end

        // CLEAR interrupted by reset, then a normal draw.
        ready_pct = 100;
        clear_book();
        i1 = mk(5, 3, 3, 3, 4);
        model(i1);
        tick(1'b1, i1);
        repeat (60) tick(1'b0, '0);
        check("clear_we_active", 32'(fb_we), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_fb_we", 32'(fb_we), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("clear_no_done", 32'(done_cycle.size()), 32'd0);
        repeat (2) tick(1'b0, '0);
        @(posedge hf_clk);
        #1;
        rst = 1'b0;
        run_cmd(mk(1, 10, 5, 1, 3), 20, s);
        check("post_rst_we_latency", 32'(first_we - s), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
